top_level: RTL and testbench
============================

Name: top_level

Overview:
- Top of the lab processor block: a self-sequencing engine that reads two signed 16-bit operands from its internal data memory and multiplies them.
- It writes the signed 32-bit product back to data memory and raises a done flag.
- Contains a 256x8 data memory (instance DM1, array Core) and a 16x8 register file (instance RF1, array Registers).
- Benches preload and inspect both arrays hierarchically through these instance and array names.

Parameters:
- A_ADDR, 0: DM byte address of operand A; MSB at A_ADDR, LSB at A_ADDR+1.
- B_ADDR, 2: DM byte address of operand B; MSB first.
- P_ADDR, 4: DM byte address of the 32-bit product; MSB at P_ADDR, LSB at P_ADDR+3.
- DM_DEPTH, 256: data memory depth in bytes.

Ports:
- Clk  input  1  single system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request: a high pulse arms the engine, and its deassertion launches a run.
- Ack  output  1  done flag.

Behaviour:
- One clock; reset is asynchronous and active-low. Reset=0 forces FSM=IDLE, Ack=0, internal counters and accumulators to 0.
- Reset does not clear DM1.Core or RF1.Registers; contents survive reset so benches can preload.
- DM1 is 8-bit wide, 8-bit address, combinational read, synchronous write on the rising edge. RF1 uses the same access rules.
- FSM states: IDLE, ARMED, LOAD, MUL, STORE, DONE.
  - IDLE: Start sampled 1 -> ARMED.
  - ARMED: stay while Start=1. Start sampled 0 -> LOAD; this edge is cycle 0.
  - LOAD: 4 cycles. Copy Core[A_ADDR..A_ADDR+3] into RF1.Registers[0..3] (A msb, A lsb, B msb, B lsb), one byte per cycle.
  - MUL: 16 cycles of signed shift-add (radix-2 Booth or equivalent) on the 16-bit operands, producing an exact 32-bit two's-complement product. The product goes to RF1.Registers[4..7], MSB first.
  - STORE: 4 cycles. Write Registers[4..7] to Core[P_ADDR..P_ADDR+3], MSB first.
  - DONE: Ack=1 from the 25th rising edge after cycle 0. Hold Ack=1 until Start is sampled 1, then Ack=0 and go to ARMED.
- Ack is registered and never glitches. Ack=0 in every state except DONE.
- Arithmetic is full 16x16 -> 32 signed. There is no overflow case; -32768*-32768 = +2^30.
- Only Core[P_ADDR..P_ADDR+3] and RF1.Registers[0..7] are written during a run. All other bytes are untouched.
- Start pulses while in LOAD/MUL/STORE are ignored; a run always completes.
- Reset asserted mid-run aborts immediately: IDLE, Ack=0. Product bytes already stored stay as written; remaining bytes are not written.
- Start held high across reset release: IDLE sees Start=1 -> ARMED. The run launches on Start's fall.
- Operands are read fresh at each run, so back-to-back runs with new preloads work without reset.

Test Plan:
- Core[0..3]=03 06 FD FA (774 * -518), pulse Start high 2 cycles then low -> Ack rises 25 cycles after the fall; Core[4..7]=FF F9 E1 DC; Core[8..255] unchanged.
- Operands 0003 and 0005 -> Core[4..7]=00 00 00 0F; RF1.Registers[0..3]=00 03 00 05.
- Boundary operands: 8000*8000 -> 40 00 00 00; 7FFF*7FFF -> 3F FF 00 01; FFFF*0001 -> FF FF FF FF; 0000*8000 -> 00 00 00 00.
- Reset pulled low during MUL -> Ack=0 immediately, FSM in IDLE; a later Start pulse without reloading produces the correct product.
- After Ack=1, load new operands and pulse Start -> Ack drops on the first Start-high edge, rises again 25 cycles after the fall with the new product.
- Start toggled during STORE -> ignored; run finishes with correct result and single Ack assertion.

Source files
------------

// File: rtl/top_level.sv
// Lab processor block: self-sequencing engine that loads two signed 16-bit
// operands from data memory, multiplies them with a radix-2 Booth sequence,
// parks the 32-bit product in the register file and stores it back to memory.

// 256x8 data memory: combinational read, synchronous write, no reset so
// preloaded contents survive a reset.
module lab_dm #(
  parameter int DEPTH = 256
) (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] Core [0:DEPTH-1];

  // Byte write on the rising edge
  always_ff @(posedge clk) begin
    if (we) begin
      Core[addr] <= wdata;
    end
  end

  assign rdata = Core[addr];
endmodule

// 16x8 register file: combinational read, synchronous write. Besides the
// byte write port it has a product port that fills Registers[4..7] (MSB
// first) in one edge, so the final Booth step can park the whole product.
module lab_rf (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [7:0]  wdata,
  input  logic        we_prod,
  input  logic [31:0] prod,
  input  logic [3:0]  raddr,
  output logic [7:0]  rdata
);
  logic [7:0] Registers [0:15];

  // Byte write or product write on the rising edge (never both at once)
  always_ff @(posedge clk) begin
    if (we_prod) begin
      Registers[4] <= prod[31:24];
      Registers[5] <= prod[23:16];
      Registers[6] <= prod[15:8];
      Registers[7] <= prod[7:0];
    end else if (we) begin
      Registers[waddr] <= wdata;
    end
  end

  assign rdata = Registers[raddr];
endmodule

module top_level #(
  parameter int A_ADDR   = 0,
  parameter int B_ADDR   = 2,
  parameter int P_ADDR   = 4,
  parameter int DM_DEPTH = 256
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_LOAD  = 3'd2,
    S_MUL   = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] A_BASE = A_ADDR[7:0];
  localparam logic [7:0] B_BASE = B_ADDR[7:0];
  localparam logic [7:0] P_BASE = P_ADDR[7:0];

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] op_q, op_d;          // first three operand bytes gathered in LOAD
  logic [15:0] mcand_q, mcand_d;    // multiplicand (operand A)
  logic [16:0] hi_q, hi_d;          // Booth accumulator, one guard bit for -32768
  logic [15:0] lo_q, lo_d;          // multiplier shifting out, product low half shifting in
  logic        qm1_q, qm1_d;        // Booth Q(-1) bit
  logic        ack_q, ack_d;

  logic        dm_we;
  logic [7:0]  dm_addr, dm_wdata, dm_rdata;
  logic        rf_we, rf_we_prod;
  logic [3:0]  rf_waddr, rf_raddr;
  logic [7:0]  rf_wdata, rf_rdata;
  logic [31:0] rf_prod;

  logic [31:0] op_shift_s;
  logic [7:0]  load_addr_s;
  logic [16:0] mcand_ext_s, sum_s;
  logic [16:0] step_hi_s;
  logic [15:0] step_lo_s;
  logic        step_qm1_s;

  lab_dm #(.DEPTH(DM_DEPTH)) DM1 (
    .clk   (Clk),
    .we    (dm_we),
    .addr  (dm_addr),
    .wdata (dm_wdata),
    .rdata (dm_rdata)
  );

  lab_rf RF1 (
    .clk     (Clk),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .we_prod (rf_we_prod),
    .prod    (rf_prod),
    .raddr   (rf_raddr),
    .rdata   (rf_rdata)
  );

  assign op_shift_s  = {op_q, dm_rdata};
  assign load_addr_s = cnt_q[1] ? (B_BASE + {7'd0, cnt_q[0]}) : (A_BASE + {7'd0, cnt_q[0]});
  assign mcand_ext_s = {mcand_q[15], mcand_q};

  // One Booth step: add/subtract the multiplicand on a 01/10 bit pair, then
  // arithmetic-shift {hi, lo, qm1} right by one
  always_comb begin
    case ({lo_q[0], qm1_q})
      2'b01:   sum_s = hi_q + mcand_ext_s;
      2'b10:   sum_s = hi_q - mcand_ext_s;
      default: sum_s = hi_q;
    endcase
    step_hi_s  = {sum_s[16], sum_s[16:1]};
    step_lo_s  = {sum_s[0], lo_q[15:1]};
    step_qm1_s = lo_q[0];
  end

  // Next-state and datapath control for the run sequence
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    mcand_d    = mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    qm1_d      = qm1_q;
    dm_we      = 1'b0;
    dm_addr    = 8'd0;
    dm_wdata   = 8'd0;
    rf_we      = 1'b0;
    rf_waddr   = 4'd0;
    rf_wdata   = 8'd0;
    rf_we_prod = 1'b0;
    rf_prod    = 32'd0;
    rf_raddr   = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_ARMED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        if (!Start) begin
          state_d = S_LOAD;
          cnt_d   = 5'd0;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_LOAD: begin
        dm_addr  = load_addr_s;
        rf_we    = 1'b1;
        rf_waddr = {2'b00, cnt_q[1:0]};
        rf_wdata = dm_rdata;
        op_d     = op_shift_s[23:0];
        if (cnt_q == 5'd3) begin
          state_d = S_MUL;
          cnt_d   = 5'd0;
          mcand_d = op_shift_s[31:16];
          lo_d    = op_shift_s[15:0];
          hi_d    = 17'd0;
          qm1_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_MUL: begin
        hi_d  = step_hi_s;
        lo_d  = step_lo_s;
        qm1_d = step_qm1_s;
        if (cnt_q == 5'd15) begin
          rf_we_prod = 1'b1;
          rf_prod    = {step_hi_s[15:0], step_lo_s};
          state_d    = S_STORE;
          cnt_d      = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_STORE: begin
        rf_raddr = 4'd4 + {2'b00, cnt_q[1:0]};
        dm_we    = 1'b1;
        dm_addr  = P_BASE + {6'd0, cnt_q[1:0]};
        dm_wdata = rf_rdata;
        if (cnt_q == 5'd3) begin
          state_d = S_DONE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DONE: begin
        if (Start) begin
          state_d = S_ARMED;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Ack rises one edge after DONE is entered and drops on the Start edge that leaves it
  assign ack_d = (state_q == S_DONE) && !Start;

  // State, counters, accumulators and the registered Ack flag
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 24'd0;
      mcand_q <= 16'd0;
      hi_q    <= 17'd0;
      lo_q    <= 16'd0;
      qm1_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qm1_q   <= qm1_d;
      ack_q   <= ack_d;
    end
  end

  assign Ack = ack_q;
endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: table-driven product vectors, random operands against
// a plain-arithmetic model, and hand-written reset / re-run / Start-glitch sequences.
module tb_top_level;
  logic Clk;
  logic Reset;
  logic Start;
  logic Ack;

  int total = 0;
  int bad   = 0;

  logic [7:0] snap [0:255];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  top_level dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Ack   (Ack)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] model_mul(input logic [15:0] a, input logic [15:0] b);
    int ai;
    int bi;
    ai = $signed(a);
    bi = $signed(b);
    return 32'(ai * bi);
  endfunction

  task automatic preload(input logic [15:0] a, input logic [15:0] b);
    dut.DM1.Core[0] = a[15:8];
    dut.DM1.Core[1] = a[7:0];
    dut.DM1.Core[2] = b[15:8];
    dut.DM1.Core[3] = b[7:0];
    for (int i = 0; i < 256; i++) snap[i] = dut.DM1.Core[i];
  endtask

  // Start high for two cycles, then low; next rising edge is cycle 0
  task automatic launch();
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    chk("ack_low_on_start", {31'd0, Ack}, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic finish_run(input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] req, input string nm, input bit toggle);
    int diffs;
    for (int c = 0; c <= 25; c++) begin
      @(posedge Clk);
      #1;
      if (c == 24) chk({nm, "_ack_edge24"}, {31'd0, Ack}, 32'd0);
      if (c == 25) chk({nm, "_ack_edge25"}, {31'd0, Ack}, 32'd1);
      if (toggle && c == 21) Start = 1'b1;
      if (toggle && c == 22) Start = 1'b0;
    end
    chk({nm, "_core_prod"}, {dut.DM1.Core[4], dut.DM1.Core[5], dut.DM1.Core[6], dut.DM1.Core[7]}, req);
    chk({nm, "_rf_ops"}, {dut.RF1.Registers[0], dut.RF1.Registers[1],
                          dut.RF1.Registers[2], dut.RF1.Registers[3]}, {a, b});
    chk({nm, "_rf_prod"}, {dut.RF1.Registers[4], dut.RF1.Registers[5],
                           dut.RF1.Registers[6], dut.RF1.Registers[7]}, req);
    diffs = 0;
    for (int i = 0; i < 256; i++) begin
      if (!(i >= 4 && i <= 7) && dut.DM1.Core[i] !== snap[i]) diffs++;
    end
    chk({nm, "_untouched"}, 32'(diffs), 32'd0);
    if (toggle) begin
      diffs = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge Clk);
        #1;
        if (Ack !== 1'b1) diffs++;
      end
      chk({nm, "_ack_held"}, 32'(diffs), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;

    vecs[0] = '{16'h0306, 16'hFDFA, 32'hFFF9E1DC};
    vecs[1] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[2] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    vecs[4] = '{16'hFFFF, 16'h0001, 32'hFFFFFFFF};
    vecs[5] = '{16'h0000, 16'h8000, 32'h00000000};

    Reset = 1'b0;
    Start = 1'b0;
    for (int i = 0; i < 256; i++) dut.DM1.Core[i] = 8'($urandom_range(0, 255));
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_ack", {31'd0, Ack}, 32'd0);
    chk("reset_state", {29'd0, dut.state_q}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    // Table vectors; Start pulse doubles as the Ack-drop check after the first run
    for (int v = 0; v < 6; v++) begin
      preload(vecs[v].a, vecs[v].b);
      launch();
      finish_run(vecs[v].a, vecs[v].b, vecs[v].exp, $sformatf("vec%0d", v), 1'b0);
    end

    // Random operands against the arithmetic model
    for (int r = 0; r < 8; r++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      preload(ra, rb);
      launch();
      finish_run(ra, rb, model_mul(ra, rb), $sformatf("rnd%0d", r), 1'b0);
    end

    // Reset during MUL: abort, product bytes untouched, then rerun without reloading
    preload(16'h1234, 16'hF00D);
    dut.DM1.Core[4] = 8'hAA;
    dut.DM1.Core[5] = 8'hAA;
    dut.DM1.Core[6] = 8'hAA;
    dut.DM1.Core[7] = 8'hAA;
    launch();
    repeat (10) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("midrun_ack", {31'd0, Ack}, 32'd0);
    chk("midrun_state", {29'd0, dut.state_q}, 32'd0);
    chk("midrun_core", {dut.DM1.Core[4], dut.DM1.Core[5], dut.DM1.Core[6], dut.DM1.Core[7]},
        32'hAAAAAAAA);
    // Start held high across reset release: run launches on its fall
    Start = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("armed_after_reset", {29'd0, dut.state_q}, 32'd1);
    Start = 1'b0;
    finish_run(16'h1234, 16'hF00D, model_mul(16'h1234, 16'hF00D), "rerun", 1'b0);

    // Start glitch during STORE is ignored, single Ack assertion
    preload(16'hC350, 16'h0BB8);
    launch();
    finish_run(16'hC350, 16'h0BB8, model_mul(16'hC350, 16'h0BB8), "store_glitch", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
